// File: rtl/ks_add_sequencer.sv
// rtl/ks_add_sequencer.sv - multi-precision add/sub sequencer driving one external W-bit Kogge-Stone adder (optional out_zero via KS_ADD_SEQ_ZERO_FLAG_EN)
module ks_add_sequencer #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*W-1:0] in_a,
  input  logic [WORDS*W-1:0] in_b,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [W-1:0]       ks_a,
  output logic [W-1:0]       ks_b,
  output logic               ks_cin,
  input  logic [W-1:0]       ks_sum,
  input  logic               ks_cout,
  output logic               busy
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
  ,output logic              out_zero
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [WORDS*W-1:0] a_reg;
  logic [WORDS*W-1:0] b_reg;   // B already inverted for subtract
  logic               carry;
  logic [IW-1:0]      idx;
  logic               last_slice;

  assign last_slice = (idx == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode, handshake outputs and adder slice drive
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    ks_a       = '0;
    ks_b       = '0;
    ks_cin     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        ks_a   = a_reg[idx*W +: W];
        ks_b   = b_reg[idx*W +: W];
        ks_cin = carry;
        if (last_slice) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice result and carry per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b ^ {(WORDS*W){in_sub}};
            carry <= in_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          out_sum[idx*W +: W] <= ks_sum;
          carry               <= ks_cout;
          if (last_slice) begin
            idx      <= '0;
            out_cout <= ks_cout;
            // Top slice operands are the operand sign bits
            out_ovf  <= (ks_a[W-1] == ks_b[W-1]) & (ks_sum[W-1] != ks_a[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
  logic zero_acc;

  // Sticky all-zero tracking across slices, published with the final slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        zero_acc <= 1'b1;
      end else if (state == RUN) begin
        zero_acc <= zero_acc & ~|ks_sum;
        if (last_slice) out_zero <= zero_acc & ~|ks_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ks_add_sequencer.sv
// tb/tb_ks_add_sequencer.sv - directed self-checking bench for ks_add_sequencer
module tb_ks_add_sequencer;

  localparam int W     = 16;
  localparam int WORDS = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_a;
  logic [63:0]       in_b;
  logic              in_sub;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_sum;
  logic              out_cout;
  logic              out_ovf;
  logic [W-1:0]      ks_a;
  logic [W-1:0]      ks_b;
  logic              ks_cin;
  logic [W-1:0]      ks_sum;
  logic              ks_cout;
  logic              busy;
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
  logic              out_zero;
`endif

  int checks   = 0;
  int failures = 0;

  ks_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .ks_a     (ks_a),
    .ks_b     (ks_b),
    .ks_cin   (ks_cin),
    .ks_sum   (ks_sum),
    .ks_cout  (ks_cout),
    .busy     (busy)
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
    ,.out_zero(out_zero)
`endif
  );

  // Stand-in for the external Kogge-Stone adder
  assign {ks_cout, ks_sum} = {1'b0, ks_a} + {1'b0, ks_b} + {{W{1'b0}}, ks_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] r_sum;
  logic        r_cout, r_ovf, r_zero;
  int          r_lat;

  // Issue one request, wait for out_valid, optionally complete the output handshake
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input bit release_out);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 64'hDEAD_BEEF_CAFE_F00D; in_b = 64'h0123_4567_89AB_CDEF; in_sub = ~sub;
    r_lat = 0;
    while (!out_valid && r_lat < 20) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_sum = out_sum; r_cout = out_cout; r_ovf = out_ovf;
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
    r_zero = out_zero;
`else
    r_zero = 1'b0;
`endif
    if (release_out) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (out_sum !== 64'h0) begin failures++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
    checks++; if ({out_cout, out_ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {out_cout, out_ovf}); end
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%0b exp=0", out_zero); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({ks_a, ks_b, ks_cin} !== 33'h0) begin failures++; $display("FAIL idle_ks_drive got=%h exp=0", {ks_a, ks_b, ks_cin}); end
  endtask

  task automatic test_carry_chain;
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1);
    checks++; if (r_lat !== 4) begin failures++; $display("FAIL chain_latency got=%0d exp=4", r_lat); end
    checks++; if (r_sum !== 64'h0000_0000_0001_0000) begin failures++; $display("FAIL chain_sum got=%h exp=0000000000010000", r_sum); end
    checks++; if ({r_cout, r_ovf} !== 2'b00) begin failures++; $display("FAIL chain_flags got=%b exp=00", {r_cout, r_ovf}); end
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
    checks++; if (r_zero !== 1'b0) begin failures++; $display("FAIL chain_zero got=%0b exp=0", r_zero); end
`endif
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL chain_release got valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_wrap;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    checks++; if (r_sum !== 64'h0) begin failures++; $display("FAIL wrap_sum got=%h exp=0", r_sum); end
    checks++; if ({r_cout, r_ovf} !== 2'b10) begin failures++; $display("FAIL wrap_flags got=%b exp=10", {r_cout, r_ovf}); end
`ifdef KS_ADD_SEQ_ZERO_FLAG_EN
    checks++; if (r_zero !== 1'b1) begin failures++; $display("FAIL wrap_zero got=%0b exp=1", r_zero); end
`endif
  endtask

  task automatic test_sub;
    run_op(64'h5, 64'h7, 1'b1, 1'b1);
    checks++; if (r_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL sub_neg_sum got=%h exp=fffffffffffffffe", r_sum); end
    checks++; if ({r_cout, r_ovf} !== 2'b00) begin failures++; $display("FAIL sub_neg_flags got=%b exp=00", {r_cout, r_ovf}); end
    run_op(64'h7, 64'h5, 1'b1, 1'b1);
    checks++; if (r_sum !== 64'h2) begin failures++; $display("FAIL sub_pos_sum got=%h exp=2", r_sum); end
    checks++; if ({r_cout, r_ovf} !== 2'b10) begin failures++; $display("FAIL sub_pos_flags got=%b exp=10", {r_cout, r_ovf}); end
  endtask

  task automatic test_overflow;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    checks++; if (r_sum !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_sum got=%h exp=8000000000000000", r_sum); end
    checks++; if ({r_cout, r_ovf} !== 2'b01) begin failures++; $display("FAIL ovf_flags got=%b exp=01", {r_cout, r_ovf}); end
  endtask

  task automatic test_back_to_back;
    run_op(64'h7, 64'h5, 1'b1, 1'b0);
    checks++; if (r_sum !== 64'h2) begin failures++; $display("FAIL hold_first_sum got=%h exp=2", r_sum); end
    @(negedge clk);
    in_a = 64'h3; in_b = 64'h4; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 64'h2 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got ready=%0b valid=%0b sum=%h cout=%0b ovf=%0b exp 0 1 2 1 0",
                 i, in_ready, out_valid, out_sum, out_cout, out_ovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL hold_to_idle got valid=%0b ready=%0b busy=%0b exp 0 1 0", out_valid, in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL hold_reaccept got busy=%0b ready=%0b exp 1 0", busy, in_ready); end
    r_lat = 0;
    while (!out_valid && r_lat < 20) begin @(posedge clk); #1; r_lat++; end
    checks++; if (r_lat !== 4 || out_sum !== 64'h7 || out_cout !== 1'b0) begin failures++; $display("FAIL hold_second got lat=%0d sum=%h cout=%0b exp 4 7 0", r_lat, out_sum, out_cout); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit seen_valid;
    @(negedge clk);
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1111_1111_1111_1111; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_sum !== 64'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_clear got sum=%h valid=%0b busy=%0b exp 0 0 0", out_sum, out_valid, busy); end
    checks++; if ({ks_a, ks_b, ks_cin, out_cout, out_ovf} !== 35'h0) begin failures++; $display("FAIL midrst_ks got=%h exp=0", {ks_a, ks_b, ks_cin, out_cout, out_ovf}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_valid got=%0b exp=0", seen_valid); end
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
    checks++; if (r_lat !== 4 || r_sum !== 64'h2345_6789_ABCD_F001 || r_cout !== 1'b0) begin failures++; $display("FAIL midrst_next got lat=%0d sum=%h cout=%0b exp 4 23456789abcdf001 0", r_lat, r_sum, r_cout); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
